// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes from the current state, and traps on illegal opcodes or stalled memory.
module multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic        ir_load,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        alu_src,
    output logic        busy,
    output logic        illegal,
    output logic        timeout,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // The wait counter holds the number of stalled request cycles already seen,
    // so the last permitted stall is MEM_TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    logic [6:0]  r_opcode;
    logic [7:0]  r_wait;
    logic        r_illegal;
    logic        r_timeout;
    logic [31:0] r_retired;

    logic w_is_r, w_is_load, w_is_store, w_is_branch;
    logic w_is_lui, w_is_jal, w_is_jalr, w_is_mem, w_legal;
    logic w_unused;

    assign w_is_r      = (r_opcode == OP_R);
    assign w_is_load   = (r_opcode == OP_LOAD);
    assign w_is_store  = (r_opcode == OP_STORE);
    assign w_is_branch = (r_opcode == OP_BR);
    assign w_is_lui    = (r_opcode == OP_LUI);
    assign w_is_jal    = (r_opcode == OP_JAL);
    assign w_is_jalr   = (r_opcode == OP_JALR);
    assign w_is_mem    = w_is_load | w_is_store;
    assign w_legal     = w_is_r | (r_opcode == OP_I) | w_is_mem | w_is_branch |
                         w_is_lui | (r_opcode == OP_AUIPC) | w_is_jal | w_is_jalr;
    assign w_unused    = ^instr[31:7];

    assign state   = r_state;
    assign illegal = r_illegal;
    assign timeout = r_timeout;
    assign retired = r_retired;
    assign busy    = (r_state != S_IDLE) && (r_state != S_TRAP);

    // Acks reach the strobes only through the state gating below.
    always_comb begin
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = 2'b00;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        alu_src   = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            S_EXEC: begin
                alu_src = ~(w_is_r | w_is_branch);
                if (w_is_branch) begin
                    pc_write = 1'b1;
                    pc_sel   = branch_taken ? 2'b01 : 2'b00;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                alu_src  = 1'b1;
                pc_write = w_is_store & dmem_ack;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (w_is_load)                  wb_sel = 2'b01;
                else if (w_is_jal || w_is_jalr) wb_sel = 2'b10;
                else if (w_is_lui)              wb_sel = 2'b11;
                if (w_is_jal)       pc_sel = 2'b01;
                else if (w_is_jalr) pc_sel = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_opcode  <= 7'd0;
            r_wait    <= 8'd0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_retired <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_wait  <= 8'd0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_opcode <= instr[6:0];
                        r_state  <= S_DECODE;
                    end else if (r_wait == WAIT_LAST) begin
                        r_state   <= S_TRAP;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_is_mem) begin
                        r_state <= S_MEM;
                        r_wait  <= 8'd0;
                    end else if (!w_is_branch) begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (w_is_load) r_state <= S_WB;
                    end else if (r_wait == WAIT_LAST) begin
                        r_state   <= S_TRAP;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: ;
            endcase
            // Every retiring state leaves through here; stop only matters on this cycle.
            if (pc_write) begin
                r_retired <= r_retired + 32'd1;
                r_state   <= stop ? S_IDLE : S_FETCH;
                r_wait    <= 8'd0;
            end
        end
    end

endmodule
